// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle CPU core driven by board switches/buttons, presenting
// each completed instruction to the LCD controller over a valid/ready handshake.
module cpu_core_param #(
   parameter  int unsigned DATA_W      = 16,
   parameter  int unsigned REG_AW      = 4,
   parameter  int unsigned IMM_W       = 6,
   parameter  int unsigned WAIT_CYCLES = 50000,
   parameter  int unsigned CNT_W       = 16,
   localparam int unsigned INSTR_W     = 3 + 2*REG_AW + 1 + IMM_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               send,
   input  logic [INSTR_W-1:0] switches,
   output logic               disp_valid,
   input  logic               disp_ready,
   output logic [2:0]         disp_opcode,
   output logic [REG_AW-1:0]  disp_rd,
   output logic [REG_AW-1:0]  disp_rs1,
   output logic [REG_AW-1:0]  disp_rs2,
   output logic [DATA_W-1:0]  disp_value,
   output logic               disp_ovf,
   output logic               busy,
   output logic [2:0]         state_o,
   output logic [CNT_W-1:0]   instr_count
);

   localparam int unsigned NREGS  = 2**REG_AW;
   localparam int unsigned HOLD_W = $clog2(WAIT_CYCLES + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_DECODE  = 3'd2;
   localparam logic [2:0] S_EXECUTE = 3'd3;
   localparam logic [2:0] S_WBACK   = 3'd4;
   localparam logic [2:0] S_DISPLAY = 3'd5;
   localparam logic [2:0] S_HOLD    = 3'd6;

   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_ADD   = 3'd1;
   localparam logic [2:0] OP_ADDI  = 3'd2;
   localparam logic [2:0] OP_SUB   = 3'd3;
   localparam logic [2:0] OP_SUBI  = 3'd4;
   localparam logic [2:0] OP_MUL   = 3'd5;
   localparam logic [2:0] OP_CLEAR = 3'd6;
   localparam logic [2:0] OP_DISP  = 3'd7;

   logic [2:0]                   state_q, state_d;
   logic                         start_prev_q, start_prev_d;
   logic                         send_prev_q, send_prev_d;
   logic [INSTR_W-1:0]           instr_q, instr_d;
   logic [2:0]                   op_q, op_d;
   logic [REG_AW-1:0]            rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [DATA_W-1:0]            operand_q, operand_d;
   logic [DATA_W-1:0]            result_q, result_d;
   logic                         ovf_q, ovf_d;
   logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [HOLD_W-1:0]            hold_cnt_q, hold_cnt_d;
   logic                         disp_valid_q, disp_valid_d;
   logic [2:0]                   disp_opcode_q, disp_opcode_d;
   logic [REG_AW-1:0]            disp_rd_q, disp_rd_d;
   logic [REG_AW-1:0]            disp_rs1_q, disp_rs1_d;
   logic [REG_AW-1:0]            disp_rs2_q, disp_rs2_d;
   logic [DATA_W-1:0]            disp_value_q, disp_value_d;
   logic                         disp_ovf_q, disp_ovf_d;
   logic                         busy_q, busy_d;
   logic [CNT_W-1:0]             instr_count_q, instr_count_d;

   logic                         start_edge_c, send_edge_c;
   logic [DATA_W-1:0]            imm_ext_c, ra_c, rb_c, alu_res_c;
   logic [2*DATA_W-1:0]          a_w_c, b_w_c, imm_w_c, wide_c;
   logic                         alu_ovf_c;

   assign start_edge_c = start & ~start_prev_q;
   assign send_edge_c  = send & ~send_prev_q;
   assign imm_ext_c    = DATA_W'(instr_q[IMM_W-1:0]);

   // ALU: operands sign-extended to 2*DATA_W so the exact result is always representable
   always_comb begin
      ra_c      = regs_q[rs1_q];
      rb_c      = regs_q[rs2_q];
      a_w_c     = {{DATA_W{ra_c[DATA_W-1]}}, ra_c};
      b_w_c     = {{DATA_W{rb_c[DATA_W-1]}}, rb_c};
      imm_w_c   = {{DATA_W{operand_q[DATA_W-1]}}, operand_q};
      wide_c    = '0;
      case (op_q)
         OP_LOAD:  wide_c = imm_w_c;
         OP_ADD:   wide_c = a_w_c + b_w_c;
         OP_ADDI:  wide_c = a_w_c + imm_w_c;
         OP_SUB:   wide_c = a_w_c - b_w_c;
         OP_SUBI:  wide_c = a_w_c - imm_w_c;
         OP_MUL:   wide_c = a_w_c * imm_w_c;
         OP_CLEAR: wide_c = '0;
         default:  wide_c = a_w_c;
      endcase
      alu_res_c = wide_c[DATA_W-1:0];
      alu_ovf_c = (op_q inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL}) &&
                  (wide_c != {{DATA_W{wide_c[DATA_W-1]}}, wide_c[DATA_W-1:0]});
   end

   // Sequencer, register file update and display payload
   always_comb begin
      state_d       = state_q;
      start_prev_d  = start;
      send_prev_d   = send;
      instr_d       = instr_q;
      op_d          = op_q;
      rd_d          = rd_q;
      rs1_d         = rs1_q;
      rs2_d         = rs2_q;
      operand_d     = operand_q;
      result_d      = result_q;
      ovf_d         = ovf_q;
      regs_d        = regs_q;
      hold_cnt_d    = hold_cnt_q;
      disp_valid_d  = disp_valid_q;
      disp_opcode_d = disp_opcode_q;
      disp_rd_d     = disp_rd_q;
      disp_rs1_d    = disp_rs1_q;
      disp_rs2_d    = disp_rs2_q;
      disp_value_d  = disp_value_q;
      disp_ovf_d    = disp_ovf_q;
      instr_count_d = instr_count_q;

      case (state_q)
         S_IDLE: begin
            if (start_edge_c) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (send_edge_c) begin
               instr_d = switches;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            op_d      = instr_q[INSTR_W-1 -: 3];
            rd_d      = instr_q[INSTR_W-4 -: REG_AW];
            rs1_d     = instr_q[INSTR_W-4-REG_AW -: REG_AW];
            rs2_d     = instr_q[IMM_W -: REG_AW];
            operand_d = instr_q[IMM_W] ? -imm_ext_c : imm_ext_c;
            state_d   = S_EXECUTE;
         end
         S_EXECUTE: begin
            result_d = alu_res_c;
            ovf_d    = alu_ovf_c;
            state_d  = S_WBACK;
         end
         S_WBACK: begin
            if (op_q == OP_CLEAR) regs_d = '0;
            else if (op_q != OP_DISP) regs_d[rd_q] = result_q;
            disp_valid_d  = 1'b1;
            disp_opcode_d = op_q;
            disp_rd_d     = rd_q;
            disp_rs1_d    = rs1_q;
            disp_rs2_d    = rs2_q;
            disp_value_d  = result_q;
            disp_ovf_d    = ovf_q;
            state_d       = S_DISPLAY;
         end
         S_DISPLAY: begin
            if (disp_valid_q && disp_ready) begin
               disp_valid_d  = 1'b0;
               instr_count_d = instr_count_q + CNT_W'(1);
               hold_cnt_d    = '0;
               state_d       = S_HOLD;
            end
         end
         S_HOLD: begin
            if (hold_cnt_q < HOLD_W'(WAIT_CYCLES)) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if ((hold_cnt_d == HOLD_W'(WAIT_CYCLES)) && !send) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_FETCH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         start_prev_q  <= 1'b0;
         send_prev_q   <= 1'b0;
         instr_q       <= '0;
         op_q          <= '0;
         rd_q          <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         operand_q     <= '0;
         result_q      <= '0;
         ovf_q         <= 1'b0;
         regs_q        <= '0;
         hold_cnt_q    <= '0;
         disp_valid_q  <= 1'b0;
         disp_opcode_q <= '0;
         disp_rd_q     <= '0;
         disp_rs1_q    <= '0;
         disp_rs2_q    <= '0;
         disp_value_q  <= '0;
         disp_ovf_q    <= 1'b0;
         busy_q        <= 1'b0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         start_prev_q  <= start_prev_d;
         send_prev_q   <= send_prev_d;
         instr_q       <= instr_d;
         op_q          <= op_d;
         rd_q          <= rd_d;
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
         operand_q     <= operand_d;
         result_q      <= result_d;
         ovf_q         <= ovf_d;
         regs_q        <= regs_d;
         hold_cnt_q    <= hold_cnt_d;
         disp_valid_q  <= disp_valid_d;
         disp_opcode_q <= disp_opcode_d;
         disp_rd_q     <= disp_rd_d;
         disp_rs1_q    <= disp_rs1_d;
         disp_rs2_q    <= disp_rs2_d;
         disp_value_q  <= disp_value_d;
         disp_ovf_q    <= disp_ovf_d;
         busy_q        <= busy_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign disp_valid  = disp_valid_q;
   assign disp_opcode = disp_opcode_q;
   assign disp_rd     = disp_rd_q;
   assign disp_rs1    = disp_rs1_q;
   assign disp_rs2    = disp_rs2_q;
   assign disp_value  = disp_value_q;
   assign disp_ovf    = disp_ovf_q;
   assign busy        = busy_q;
   assign state_o     = state_q;
   assign instr_count = instr_count_q;

endmodule

// File: doc/cpu_core_param.md
# cpu_core_param

Parametrised multi-cycle CPU core: the next generation of the switch-driven mini CPU, with configurable data width, register count and immediate width. It adds edge-detected buttons, a signed-overflow flag and a valid/ready handshake to the display controller. The instruction word comes straight from the board switches; the internal register file is asynchronously cleared. The block sits between the board I/O (switches, buttons) and the LCD controller.

## Interface
- DATA_W, 16, register and ALU width in bits; must be ≥ IMM_W+2.
- REG_AW, 4, register address bits; the register file holds NREGS = 2**REG_AW registers.
- IMM_W, 6, immediate magnitude bits; must satisfy IMM_W+1 ≥ REG_AW.
- WAIT_CYCLES, 50000, minimum number of cycles spent in HOLD (≥1).
- CNT_W, 16, width of the completed-instruction counter.
- INSTR_W, derived, 3+2*REG_AW+1+IMM_W (18 at defaults).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  start button, already synchronised to clk; acts on its rising edge.
- send  in  1  send button, already synchronised; acts on its rising edge.
- switches  in  INSTR_W  instruction word.
- disp_valid  out  1  display payload valid.
- disp_ready  in  1  LCD controller accepts the payload.
- disp_opcode  out  3  opcode of the completed instruction.
- disp_rd, disp_rs1, disp_rs2  out  REG_AW each  decoded register fields.
- disp_value  out  DATA_W  result or displayed register value (two's complement).
- disp_ovf  out  1  signed overflow of this instruction.
- busy  out  1  high in every state except IDLE and FETCH.
- state_o  out  3  current state encoding.
- instr_count  out  CNT_W  number of completed instructions.

## Operation
- Field layout, MSB first: op[3], rd[REG_AW], rs1[REG_AW], tail[1+IMM_W].
  - Immediate formats: sign = tail MSB, imm = tail[IMM_W-1:0], operand = sign ? −imm : imm, sign-extended to DATA_W.
  - Register format: rs2 = tail[IMM_W:IMM_W+1-REG_AW].
- Opcodes:
  - 000 LOAD: rd = operand.
  - 001 ADD: rd = rs1 + rs2.
  - 010 ADDI: rd = rs1 + operand.
  - 011 SUB: rd = rs1 − rs2.
  - 100 SUBI: rd = rs1 − operand.
  - 101 MUL: rd = rs1 × operand.
  - 110 CLEAR: all registers = 0.
  - 111 DISPLAY: no write; disp_value = reg[rs1].
- Arithmetic is signed. The result wraps modulo 2^DATA_W.
- disp_ovf is set when the exact signed result does not fit in DATA_W. MUL uses the full 2·DATA_W product for this check. LOAD, CLEAR and DISPLAY report disp_ovf = 0.
- disp_value is the value written to rd. For CLEAR it is 0.
- States:
  - IDLE (0): → FETCH on a start edge.
  - FETCH (1): switches latched on a send edge → DECODE.
  - DECODE (2): fields registered → EXECUTE.
  - EXECUTE (3): ALU result and ovf registered; register file read combinationally → WRITEBACK.
  - WRITEBACK (4): register file written, or cleared for CLEAR → DISPLAY.
  - DISPLAY (5): disp_valid = 1 → HOLD on disp_valid & disp_ready.
  - HOLD (6): → FETCH once hold_cnt reaches WAIT_CYCLES and send = 0.
- Start edges outside IDLE are ignored. Send edges outside FETCH are ignored and are not queued.
- Edge detection: a one-cycle pulse when the input is 1 and its registered copy is 0.
- instr_count increments on each DISPLAY handshake and wraps.

## Timing
- Reset values:
  - All outputs 0, state IDLE.
  - All registers 0.
  - Edge-detect flops 0, hold_cnt 0.
- Reset mid-operation aborts the instruction immediately; no partial write survives.
- A send edge in FETCH at cycle N gives:
  - DECODE at N+1, EXECUTE at N+2, WRITEBACK at N+3.
  - The register updates at the end of N+3.
  - disp_valid rises at N+4.
- The disp_* payload is stable while disp_valid = 1 and is held after the handshake until the next DISPLAY.
- disp_valid drops the cycle after the handshake, and instr_count updates that same cycle.
- With disp_ready tied high, DISPLAY lasts exactly 1 cycle.
- hold_cnt:
  - Cleared on HOLD entry and incremented each HOLD cycle.
  - Saturates at WAIT_CYCLES.
  - Exit requires at least WAIT_CYCLES HOLD cycles.
  - Send held high extends HOLD indefinitely, with no re-trigger on release.
- rd = rs1 = rs2 is legal. Reads use pre-write values because the write happens in WRITEBACK.

## Test plan
- Register arithmetic, WAIT_CYCLES=4, disp_ready=1: start; LOAD R1,+5; LOAD R2,−3; ADD R3,R1,R2 → disp_value 2, disp_ovf 0, instr_count 3, disp_valid 4 cycles after each send edge.
- Multiply wrap: LOAD R1,+63; MUL R2,R1,+63 → 3969, ovf 0; MUL R3,R2,+63 → 0xD0BF (250047 mod 65536), ovf 1.
- CLEAR and DISPLAY: CLEAR → disp_value 0; DISPLAY R3 → 0, opcode 111, no register changed by DISPLAY.
- Handshake: disp_ready held low for 10 cycles → disp_valid and payload stable throughout; raise disp_ready → HOLD the next cycle, instr_count +1.
- Button discipline: send held high from FETCH through HOLD for 20 cycles → exactly one instruction; a second send edge during DISPLAY is ignored; start pressed again is ignored.
- Reset asserted in EXECUTE of ADDI R5,R1,+7 → all outputs 0, state IDLE, R5 = 0, and start is required before the next FETCH.
